pipe_instr_chain: RTL and testbench

//  Fetch PC register plus the F->D->E->M->W instruction/PC pipeline registers of the 5-stage MIPS core.

---
 rtl/pipe_instr_chain_pkg.sv | 38 +++
 rtl/pipe_instr_chain_stage_reg.sv | 33 +++
 rtl/pipe_instr_chain.sv | 119 +++++++++++
 tb/tb_pipe_instr_chain.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_instr_chain_pkg.sv
// Shared definitions for the instruction/PC pipeline of the 5-stage MIPS core.
// Contents:
//   DEF_RESET_PC, DEF_NOP, DEF_CNT_W : default parameter values for the top
//   stage_t                          : {instr, pc, valid} payload of one stage
//   op_of/funct_of/rs_of/rt_of/rd_of : MIPS instruction field extractors
package pipe_instr_chain_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP      = 32'h0000_0000;
  localparam int          DEF_CNT_W    = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } stage_t;

  function automatic logic [5:0] op_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/pipe_instr_chain_stage_reg.sv
// One pipeline stage register holding {instr, pc, valid}.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   en         : load when 1, hold when 0
//   clr        : with en, load a bubble (NOP, valid=0) but still carry pc
//   next       : payload to load
//   cur        : registered payload
module pipe_instr_chain_stage_reg
  import pipe_instr_chain_pkg::*;
#(
  parameter logic [31:0] NOP         = DEF_NOP,
  parameter bit          RESET_VALID = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   clr,
  input  stage_t next,
  output stage_t cur
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= '{instr: NOP, pc: 32'd0, valid: RESET_VALID};
    end else if (en) begin
      // A bubble keeps the PC of the held instruction so downstream PC
      // tracking stays monotonic even through inserted NOPs.
      if (clr) cur <= '{instr: NOP, pc: next.pc, valid: 1'b0};
      else     cur <= next;
    end
  end

endmodule

// File: rtl/pipe_instr_chain.sv
// Fetch PC register plus the F->D->E->M->W instruction/PC pipeline registers
// of the 5-stage MIPS core, with stall bubbling, global freeze, D-stage
// redirect (one delay slot) and a saturating bubble counter.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   instr_f           : word read from IM at pc_f
//   stall             : hold F/D, inject bubble into E
//   freeze            : hold every register
//   npc_take, npc_d   : D-stage redirect request and target
//   pc_f              : fetch address
//   InstrD..InstrW    : instruction in each stage
//   pc_d..pc_w        : PC of the instruction in each stage
//   valid_e..valid_w  : stage holds a real instruction
//   stall_cnt         : number of bubbles inserted, saturating
module pipe_instr_chain
  import pipe_instr_chain_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP      = DEF_NOP,
  parameter int          CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_f,
  input  logic             stall,
  input  logic             freeze,
  input  logic             npc_take,
  input  logic [31:0]      npc_d,
  output logic [31:0]      pc_f,
  output logic [31:0]      InstrD,
  output logic [31:0]      InstrE,
  output logic [31:0]      InstrM,
  output logic [31:0]      InstrW,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_e,
  output logic [31:0]      pc_m,
  output logic [31:0]      pc_w,
  output logic             valid_e,
  output logic             valid_m,
  output logic             valid_w,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic   en_fd;
  logic   en_pipe;
  stage_t fetch_p0;
  stage_t dec_p1;
  stage_t exe_p2;
  stage_t mem_p3;
  stage_t wb_p4;

  // freeze dominates stall; stall only holds the front end.
  assign en_pipe = !freeze;
  assign en_fd   = !freeze && !stall;

  assign fetch_p0 = '{instr: instr_f, pc: pc_f, valid: 1'b1};

  // ---- F stage: fetch PC ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (en_fd) begin
      // Redirect target is passed through unaligned; wrap past 2^32 is legal.
      pc_f <= npc_take ? npc_d : pc_f + 32'd4;
    end
  end

  // ---- F -> D ----
  // D powers up holding NOP treated as a real instruction, so the first
  // non-stalled edge always marks E valid.
  pipe_instr_chain_stage_reg #(.NOP(NOP), .RESET_VALID(1'b1)) u_dec (
    .clk(clk), .reset(reset), .en(en_fd), .clr(1'b0),
    .next(fetch_p0), .cur(dec_p1)
  );

  // ---- D -> E: bubble injected here while stalled ----
  pipe_instr_chain_stage_reg #(.NOP(NOP), .RESET_VALID(1'b0)) u_exe (
    .clk(clk), .reset(reset), .en(en_pipe), .clr(stall),
    .next(dec_p1), .cur(exe_p2)
  );

  // ---- E -> M ----
  pipe_instr_chain_stage_reg #(.NOP(NOP), .RESET_VALID(1'b0)) u_mem (
    .clk(clk), .reset(reset), .en(en_pipe), .clr(1'b0),
    .next(exe_p2), .cur(mem_p3)
  );

  // ---- M -> W ----
  pipe_instr_chain_stage_reg #(.NOP(NOP), .RESET_VALID(1'b0)) u_wb (
    .clk(clk), .reset(reset), .en(en_pipe), .clr(1'b0),
    .next(mem_p3), .cur(wb_p4)
  );

  // ---- bubble counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!freeze && stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign InstrD  = dec_p1.instr;
  assign InstrE  = exe_p2.instr;
  assign InstrM  = mem_p3.instr;
  assign InstrW  = wb_p4.instr;
  assign pc_d    = dec_p1.pc;
  assign pc_e    = exe_p2.pc;
  assign pc_m    = mem_p3.pc;
  assign pc_w    = wb_p4.pc;
  assign valid_e = exe_p2.valid;
  assign valid_m = mem_p3.valid;
  assign valid_w = wb_p4.valid;

endmodule

// File: tb/tb_pipe_instr_chain.sv
// Self-checking bench for pipe_instr_chain: directed scenarios plus a
// randomized run against a queue-of-stages reference model.
module tb_pipe_instr_chain;

  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam logic [31:0] NOPW = 32'h0000_0000;
  localparam int          CW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr_f;
  logic          stall;
  logic          freeze;
  logic          npc_take;
  logic [31:0]   npc_d;
  logic [31:0]   pc_f, InstrD, InstrE, InstrM, InstrW;
  logic [31:0]   pc_d, pc_e, pc_m, pc_w;
  logic          valid_e, valid_m, valid_w;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int fails  = 0;

  pipe_instr_chain #(.RESET_PC(RPC), .NOP(NOPW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_f(instr_f), .stall(stall),
    .freeze(freeze), .npc_take(npc_take), .npc_d(npc_d),
    .pc_f(pc_f), .InstrD(InstrD), .InstrE(InstrE), .InstrM(InstrM),
    .InstrW(InstrW), .pc_d(pc_d), .pc_e(pc_e), .pc_m(pc_m), .pc_w(pc_w),
    .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: four stage slots D,E,M,W plus fetch PC and counter.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ent_t;

  ent_t          pipe[4];
  logic [31:0]   m_pc;
  logic [CW-1:0] m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) pipe[i] = '{NOPW, 32'd0, 1'b0};
    m_pc  = RPC;
    m_cnt = '0;
  endfunction

  function automatic void model_edge();
    if (freeze) return;
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    if (stall) begin
      pipe[1] = '{NOPW, pipe[0].pc, 1'b0};
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      pipe[1] = '{pipe[0].instr, pipe[0].pc, 1'b1};
      pipe[0] = '{instr_f, m_pc, 1'b1};
      m_pc    = npc_take ? npc_d : m_pc + 32'd4;
    end
  endfunction

  function automatic logic [294:0] obs();
    return {pc_f, InstrD, InstrE, InstrM, InstrW, pc_d, pc_e, pc_m, pc_w,
            valid_e, valid_m, valid_w, stall_cnt};
  endfunction

  function automatic logic [294:0] expv();
    return {m_pc, pipe[0].instr, pipe[1].instr, pipe[2].instr, pipe[3].instr,
            pipe[0].pc, pipe[1].pc, pipe[2].pc, pipe[3].pc,
            pipe[1].valid, pipe[2].valid, pipe[3].valid, m_cnt};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic s, input logic f, input logic t,
                        input logic [31:0] tgt, input logic [31:0] w);
    stall = s; freeze = f; npc_take = t; npc_d = tgt; instr_f = w;
  endtask

  // Pulse reset between clock edges; called 1 time unit after a rising edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== {RPC, 256'd0, 3'b000, 4'd0}) begin
      $display("FAIL reset_initial: got %h expected %h", obs(), {RPC, 256'd0, 3'b000, 4'd0});
      fails++;
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(i == 5, 1'b0, 1'b0, 32'd0, $urandom);
      cycle();
      checks++;
      if (obs() !== expv()) begin
        $display("FAIL reset_prerun[%0d]: got %h expected %h", i, obs(), expv());
        fails++;
      end
    end
    // Assert mid-cycle: outputs must clear with no clock edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== {RPC, 256'd0, 3'b000, 4'd0}) begin
      $display("FAIL reset_async: got %h expected %h", obs(), {RPC, 256'd0, 3'b000, 4'd0});
      fails++;
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_straight_line();
    logic [31:0] w[5];
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'd0, w[k]);
      cycle();
      checks++;
      if (obs() !== expv()) begin
        $display("FAIL straight[%0d]: got %h expected %h", k, obs(), expv());
        fails++;
      end
      if (k == 3) begin
        checks++;
        if ({InstrW, pc_w, valid_w} !== {w[0], RPC, 1'b1}) begin
          $display("FAIL straight_first_at_w: got %h/%h/%b expected %h/%h/1",
                   InstrW, pc_w, valid_w, w[0], RPC);
          fails++;
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] x;
    x = $urandom;
    apply_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, x);
    cycle();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 1'b0, 1'b1, 32'h0000_5000, $urandom);
      cycle();
      checks++;
      if ({InstrD, pc_f, InstrE, valid_e} !== {x, 32'h0000_3004, NOPW, 1'b0}) begin
        $display("FAIL stall_hold[%0d]: got D=%h pc_f=%h E=%h ve=%b expected D=%h pc_f=00003004 E=%h ve=0",
                 k, InstrD, pc_f, InstrE, valid_e, x, NOPW);
        fails++;
      end
      checks++;
      if (obs() !== expv()) begin
        $display("FAIL stall_model[%0d]: got %h expected %h", k, obs(), expv());
        fails++;
      end
    end
    checks++;
    if (stall_cnt !== 4'd2) begin
      $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
      fails++;
    end
    set_in(1'b0, 1'b0, 1'b0, 32'd0, $urandom);
    cycle();
    checks++;
    if ({InstrE, valid_e, pc_e} !== {x, 1'b1, RPC}) begin
      $display("FAIL stall_release: got E=%h ve=%b pc_e=%h expected E=%h ve=1 pc_e=%h",
               InstrE, valid_e, pc_e, x, RPC);
      fails++;
    end
  endtask

  task automatic test_branch();
    logic [31:0] ds;
    ds = $urandom;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'd0, $urandom);
      cycle();
    end
    checks++;
    if ({pc_d, pc_f} !== {32'h0000_3008, 32'h0000_300C}) begin
      $display("FAIL branch_setup: got pc_d=%h pc_f=%h expected 00003008/0000300c", pc_d, pc_f);
      fails++;
    end
    set_in(1'b0, 1'b0, 1'b1, 32'h0000_3040, ds);
    cycle();
    checks++;
    if ({InstrD, pc_d, pc_f, pc_e} !== {ds, 32'h0000_300C, 32'h0000_3040, 32'h0000_3008}) begin
      $display("FAIL branch_redirect: got D=%h pc_d=%h pc_f=%h pc_e=%h expected D=%h 0000300c 00003040 00003008",
               InstrD, pc_d, pc_f, pc_e, ds);
      fails++;
    end
    set_in(1'b0, 1'b0, 1'b0, 32'd0, $urandom);
    cycle();
    checks++;
    if (obs() !== expv()) begin
      $display("FAIL branch_after: got %h expected %h", obs(), expv());
      fails++;
    end
  endtask

  task automatic test_freeze();
    logic [CW-1:0] cnt_before;
    for (int k = 0; k < 4; k++) begin
      set_in(k == 1, 1'b0, 1'b0, 32'd0, $urandom);
      cycle();
    end
    cnt_before = m_cnt;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b1, 1'b1, $urandom, $urandom);
      cycle();
      checks++;
      if (obs() !== expv()) begin
        $display("FAIL freeze_hold[%0d]: got %h expected %h", k, obs(), expv());
        fails++;
      end
    end
    checks++;
    if ({stall_cnt, valid_e} !== {cnt_before, pipe[1].valid}) begin
      $display("FAIL freeze_cnt: got %0d expected %0d", stall_cnt, cnt_before);
      fails++;
    end
  endtask

  task automatic test_saturation();
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 20; k++) cycle();
    checks++;
    if (stall_cnt !== 4'hF) begin
      $display("FAIL sat_cnt: got %h expected f", stall_cnt);
      fails++;
    end
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, $urandom);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, $urandom);
    cycle();
    checks++;
    if ({pc_f, pc_d, stall_cnt} !== {32'd0, 32'hFFFF_FFFC, 4'hF}) begin
      $display("FAIL pc_wrap: got pc_f=%h pc_d=%h cnt=%h expected 00000000 fffffffc f",
               pc_f, pc_d, stall_cnt);
      fails++;
    end
    set_in(1'b0, 1'b0, 1'b1, 32'h0000_1233, $urandom);
    cycle();
    checks++;
    if (pc_f !== 32'h0000_1233) begin
      $display("FAIL misaligned_target: got %h expected 00001233", pc_f);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(99) < 35, $urandom_range(99) < 10,
             $urandom_range(99) < 20, $urandom, $urandom);
      cycle();
      checks++;
      if (obs() !== expv()) begin
        $display("FAIL random[%0d]: got %h expected %h", k, obs(), expv());
        fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_stall();
    test_branch();
    test_freeze();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
